seq_instruction_decoder: RTL and testbench

- Multi-cycle successor to the combinational instruction decoder.
- Accepts instructions over a valid/ready handshake and latches each one.
- Sequences it through DECODE, optional multi-cycle EXEC and WRITEBACK.
- Drives one-hot register clock enables, source-mux select and ALU control for the lab datapath. Sits between the instruction source (program ROM/testbench) and the register file/ALU.

---
 rtl/seq_dec_pkg.sv | 27 ++
 rtl/onehot_reg_decoder.sv | 18 +
 rtl/seq_instruction_decoder.sv | 124 ++++++++++++
 tb/tb_seq_instruction_decoder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/seq_dec_pkg.sv
// Shared types and instruction field extractors for the sequential decoder.
// Instruction layout is {op[1:0], dst[rsw-1:0], src[rsw-1:0]}, zero-extended to 32 bits by callers.
package seq_dec_pkg;

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, HALT} state_t;
  typedef enum logic [1:0] {OP_NOP, OP_MOV, OP_ADD, OP_SUB} op_t;

  function automatic logic [1:0] f_op(input logic [31:0] instr, input int rsw);
    return instr[2*rsw +: 2];
  endfunction

  function automatic logic [31:0] f_dst(input logic [31:0] instr, input int rsw);
    return (instr >> rsw) & ((32'd1 << rsw) - 32'd1);
  endfunction

  function automatic logic [31:0] f_src(input logic [31:0] instr, input int rsw);
    return instr & ((32'd1 << rsw) - 32'd1);
  endfunction

  // HALT is the NOP encoding with every register-index bit set.
  function automatic logic f_is_halt(input logic [31:0] instr, input int rsw);
    logic [31:0] w_mask;
    w_mask = (32'd1 << (2*rsw)) - 32'd1;
    return (f_op(instr, rsw) == 2'b00) && ((instr & w_mask) == w_mask);
  endfunction

endpackage

// File: rtl/onehot_reg_decoder.sv
// Combinational index-to-one-hot decoder with enable; output is all zero when disabled.
// Zero latency, no flow control.
module onehot_reg_decoder
  import seq_dec_pkg::*;
#(
  parameter int REG_SEL_W = 2
) (
  input  logic                        i_en,
  input  logic [REG_SEL_W-1:0]        i_sel,
  output logic [(2**REG_SEL_W)-1:0]   o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_sel] = 1'b1;
  end

endmodule

// File: rtl/seq_instruction_decoder.sv
// Multi-cycle decoder: latches one instruction per valid/ready handshake and walks DECODE/EXEC/WB.
// Accept-to-ready: NOP 2, MOV 3, ADD/SUB 3+ALU_LAT cycles; instr_ready only in IDLE, HALT waits for resume.
module seq_instruction_decoder
  import seq_dec_pkg::*;
#(
  parameter int REG_SEL_W = 2,
  parameter int ALU_LAT   = 2,
  parameter int CNT_W     = 8,
  localparam int NUM_REGS = 2**REG_SEL_W,
  localparam int IW       = 2 + 2*REG_SEL_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IW-1:0]        instruction,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic                 resume,
  output logic [NUM_REGS-1:0]  ce_reg,
  output logic [REG_SEL_W-1:0] src_sel,
  output logic                 alu_op,
  output logic                 alu_en,
  output logic                 busy,
  output logic                 halted,
  output logic [CNT_W-1:0]     retired
);

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IW-1:0]        r_instr;
  logic [3:0]           r_cnt;
  logic [CNT_W-1:0]     r_retired;
  logic [REG_SEL_W-1:0] r_src_sel;

  op_t                  w_op;
  logic                 w_halt;
  logic [REG_SEL_W-1:0] w_dst;
  logic [REG_SEL_W-1:0] w_src;
  logic                 w_retire;
  logic                 w_cnt_load;
  logic                 w_src_load;

  assign w_op   = op_t'(f_op(32'(r_instr), REG_SEL_W));
  assign w_halt = f_is_halt(32'(r_instr), REG_SEL_W);
  assign w_dst  = REG_SEL_W'(f_dst(32'(r_instr), REG_SEL_W));
  assign w_src  = REG_SEL_W'(f_src(32'(r_instr), REG_SEL_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_retire    = 1'b0;
    w_cnt_load  = 1'b0;
    w_src_load  = 1'b0;
    case (r_state)
      IDLE:   if (instr_valid) w_state_nxt = DECODE;
      DECODE: begin
        case (w_op)
          OP_NOP: begin
            if (w_halt) begin
              w_state_nxt = HALT;
            end else begin
              w_state_nxt = IDLE;
              w_retire    = 1'b1;
            end
          end
          OP_MOV: begin
            w_state_nxt = WB;
            w_src_load  = 1'b1;
          end
          default: begin
            w_state_nxt = EXEC;
            w_cnt_load  = 1'b1;
            w_src_load  = 1'b1;
          end
        endcase
      end
      EXEC:   if (r_cnt == 4'd0) w_state_nxt = WB;
      WB: begin
        w_state_nxt = IDLE;
        w_retire    = 1'b1;
      end
      HALT:   if (resume) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // src_sel is loaded on the DECODE exit so it is already valid for the first EXEC/WB cycle and then holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr   <= '0;
      r_cnt     <= '0;
      r_retired <= '0;
      r_src_sel <= '0;
    end else begin
      if (r_state == IDLE && instr_valid) r_instr <= instruction;
      if (w_cnt_load)                           r_cnt <= CNT_INIT;
      else if (r_state == EXEC && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (w_retire)   r_retired <= r_retired + 1'b1;
      if (w_src_load) r_src_sel <= w_src;
    end
  end

  onehot_reg_decoder #(
    .REG_SEL_W (REG_SEL_W)
  ) u_ce_dec (
    .i_en     (r_state == WB),
    .i_sel    (w_dst),
    .o_onehot (ce_reg)
  );

  assign instr_ready = (r_state == IDLE);
  assign busy        = (r_state != IDLE) && (r_state != HALT);
  assign halted      = (r_state == HALT);
  assign alu_en      = (r_state == EXEC);
  assign alu_op      = (r_state == EXEC) && r_instr[IW-1 -: 2] == 2'b11;
  assign src_sel     = r_src_sel;
  assign retired     = r_retired;

endmodule

// File: tb/tb_seq_instruction_decoder.sv
// Randomized + directed bench for seq_instruction_decoder against an offset-based timeline model.
// Instance A uses default parameters; instance B uses ALU_LAT=1, CNT_W=2 for short-latency and wrap cases.
module tb_seq_instruction_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] instruction = '0;
  logic       valid = 1'b0;
  logic       resume = 1'b0;
  logic       sel = 1'b0;

  always #5 clk = ~clk;

  logic       va, vb, ra, rb;
  logic       ready_a, aluop_a, aluen_a, busy_a, halted_a;
  logic       ready_b, aluop_b, aluen_b, busy_b, halted_b;
  logic [3:0] ce_a, ce_b;
  logic [1:0] src_a, src_b;
  logic [7:0] ret_a;
  logic [1:0] ret_b;

  assign va = valid & ~sel;
  assign vb = valid & sel;
  assign ra = resume & ~sel;
  assign rb = resume & sel;

  seq_instruction_decoder dut_a (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .instr_valid(va),
    .instr_ready(ready_a), .resume(ra), .ce_reg(ce_a), .src_sel(src_a),
    .alu_op(aluop_a), .alu_en(aluen_a), .busy(busy_a), .halted(halted_a), .retired(ret_a)
  );

  seq_instruction_decoder #(.REG_SEL_W(2), .ALU_LAT(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .instr_valid(vb),
    .instr_ready(ready_b), .resume(rb), .ce_reg(ce_b), .src_sel(src_b),
    .alu_op(aluop_b), .alu_en(aluen_b), .busy(busy_b), .halted(halted_b), .retired(ret_b)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: where the current instruction is, counted in edges since its acceptance.
  int         lat;
  int         cmask;
  bit         m_act;
  int         m_k;
  logic [5:0] m_ins;
  int         m_ret;
  logic [1:0] m_src_last;

  function automatic bit is_halt(input logic [5:0] i);
    return i == 6'b001111;
  endfunction

  function automatic int ins_len(input logic [5:0] i);
    if (i[5:4] == 2'b00) return 1;
    if (i[5:4] == 2'b01) return 2;
    return 2 + lat;
  endfunction

  task automatic model_reset();
    m_act = 1'b0; m_k = 0; m_ins = '0; m_ret = 0; m_src_last = '0;
  endtask

  task automatic model_edge();
    if (!m_act) begin
      if (valid) begin m_act = 1'b1; m_k = 1; m_ins = instruction; end
    end else if (is_halt(m_ins)) begin
      if (m_k >= 2 && resume) m_act = 1'b0;
      else m_k++;
    end else if (m_k == ins_len(m_ins)) begin
      m_act = 1'b0;
      m_ret++;
      if (m_ins[5:4] != 2'b00) m_src_last = m_ins[1:0];
    end else begin
      m_k++;
    end
  endtask

  task automatic compare(input string ph);
    bit         idle, hlt, dec, wb, ex;
    logic [3:0] e_ce;
    logic [1:0] e_src;
    idle  = !m_act;
    dec   = m_act && m_k == 1;
    hlt   = m_act && is_halt(m_ins) && m_k >= 2;
    wb    = m_act && !is_halt(m_ins) && m_ins[5:4] != 2'b00 && m_k == ins_len(m_ins);
    ex    = m_act && m_ins[5] && m_k >= 2 && m_k < ins_len(m_ins);
    e_src = (wb || ex) ? m_ins[1:0] : m_src_last;
    e_ce  = wb ? (4'b0001 << m_ins[3:2]) : 4'b0000;
    check({ph, ".ready"},  32'(sel ? ready_b  : ready_a),  32'(idle));
    check({ph, ".busy"},   32'(sel ? busy_b   : busy_a),   32'(dec || ex || wb));
    check({ph, ".halted"}, 32'(sel ? halted_b : halted_a), 32'(hlt));
    check({ph, ".ce_reg"}, 32'(sel ? ce_b     : ce_a),     32'(e_ce));
    check({ph, ".alu_en"}, 32'(sel ? aluen_b  : aluen_a),  32'(ex));
    check({ph, ".src_sel"},32'(sel ? src_b    : src_a),    32'(e_src));
    check({ph, ".retired"},sel ? 32'(ret_b) : 32'(ret_a),  32'(m_ret & cmask));
    if (ex || !rst_n)
      check({ph, ".alu_op"}, 32'(sel ? aluop_b : aluop_a), ex ? 32'(m_ins[4]) : 32'd0);
  endtask

  task automatic cycle(input string ph, input logic v, input logic [5:0] ins, input logic res);
    valid = v; instruction = ins; resume = res;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare(ph);
  endtask

  task automatic do_reset(input bit s);
    @(negedge clk);
    rst_n = 1'b0; sel = s; valid = 1'b0; resume = 1'b0;
    lat   = s ? 1 : 2;
    cmask = s ? 3 : 255;
    #1;
    model_reset();
    compare("reset");
    @(negedge clk);
    rst_n = 1'b1;
    compare("post_reset");
  endtask

  task automatic idle_cycles(input string ph, input int n);
    for (int i = 0; i < n; i++) cycle(ph, 1'b0, 6'($urandom), 1'b0);
  endtask

  task automatic random_run(input string ph, input int n);
    logic [5:0] ins;
    for (int i = 0; i < n; i++) begin
      ins = ($urandom_range(0, 9) == 0) ? 6'b001111 : 6'($urandom);
      cycle(ph, 1'($urandom_range(0, 3) != 0), ins, $urandom_range(0, 5) == 0);
    end
  endtask

  initial begin
    // Instance A: default parameters.
    do_reset(1'b0);
    cycle("mov", 1'b1, 6'b011001, 1'b0);
    idle_cycles("mov", 3);
    cycle("add", 1'b1, 6'b101100, 1'b0);
    idle_cycles("add", 5);
    cycle("halt", 1'b1, 6'b001111, 1'b0);
    for (int i = 0; i < 6; i++) cycle("halt_hold", 1'b1, 6'b011001, 1'b0);
    cycle("resume", 1'b0, 6'b000000, 1'b1);
    cycle("nop", 1'b1, 6'b000000, 1'b0);
    idle_cycles("nop", 2);
    random_run("rand_a", 400);

    // Asynchronous reset between edges while an ADD is in EXEC.
    idle_cycles("pre_rst", 8);
    cycle("rst_add", 1'b1, 6'b101101, 1'b0);
    cycle("rst_add", 1'b0, 6'b000000, 1'b0);
    cycle("rst_add", 1'b0, 6'b000000, 1'b0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare("mid_exec_rst");
    @(negedge clk);
    rst_n = 1'b1;
    compare("mid_exec_rel");
    idle_cycles("after_rst", 6);

    // Instance B: ALU_LAT=1, CNT_W=2.
    do_reset(1'b1);
    cycle("sub", 1'b1, 6'b110110, 1'b0);
    idle_cycles("sub", 4);
    for (int i = 0; i < 15; i++) cycle("wrap", 1'b1, 6'b011001 ^ 6'(i & 15), 1'b0);
    idle_cycles("wrap", 3);
    random_run("rand_b", 400);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
